// File: rtl/if_mem_map_pkg.sv
// Shared types for the looped conditional memory-update engine: FSM states,
// compare-operator encodings and the number of defined operators.
package if_mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COND  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [2:0] CMP_LT  = 3'd0;
  localparam logic [2:0] CMP_GT  = 3'd1;
  localparam logic [2:0] CMP_EQ  = 3'd2;
  localparam logic [2:0] CMP_NEQ = 3'd3;
  localparam logic [2:0] CMP_LE  = 3'd4;
  localparam logic [2:0] CMP_GE  = 3'd5;

  localparam int CMP_MODES = 6;

endpackage

// File: rtl/if_mem_map_cmp.sv
// Combinational comparator: left OP right, two's complement when SIGNED=1.
// Encodings at or above CMP_MODES evaluate false.
module if_mem_map_cmp
  import if_mem_map_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic [2:0]       mode,
  output logic             result
);

  logic lt;
  logic eq;

  always_comb begin
    eq = (left == right);
    if (SIGNED) lt = ($signed(left) < $signed(right));
    else        lt = (left < right);
    case (mode)
      CMP_LT:  result = lt;
      CMP_GT:  result = !lt && !eq;
      CMP_EQ:  result = eq;
      CMP_NEQ: result = !eq;
      CMP_LE:  result = lt || eq;
      CMP_GE:  result = !lt;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_mem_map.sv
// Looped compare-then-write engine over count words starting at base.
// Optional hit counter is built only when IF_MEM_MAP_HIT_COUNT_EN is defined.
module if_mem_map
  import if_mem_map_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  done,
  input  logic [2:0]            mode,
  input  logic [WIDTH-1:0]      threshold,
  input  logic [WIDTH-1:0]      tru_val,
  input  logic [WIDTH-1:0]      fal_val,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   hit_count,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [WIDTH-1:0]      mem_write_data,
  output logic                  mem_write_en,
  input  logic [WIDTH-1:0]      mem_read_data,
  input  logic                  mem_done,
  output logic [1:0]            dbg_state
);

  // Handshakes: go is held high until done, done pulses for one cycle;
  // mem_write_en is held high until mem_done acknowledges the write.
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [2:0]            mode_q, mode_d;
  logic [WIDTH-1:0]      thr_q, thr_d;
  logic [WIDTH-1:0]      tru_q, tru_d;
  logic [WIDTH-1:0]      fal_q, fal_d;
  logic                  cond_q, cond_d;
  logic                  cmp_res;

  if_mem_map_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
    .left   (mem_read_data),
    .right  (thr_q),
    .mode   (mode_q),
    .result (cmp_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      thr_q   <= '0;
      tru_q   <= '0;
      fal_q   <= '0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      tru_q   <= tru_d;
      fal_q   <= fal_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    tru_d   = tru_q;
    fal_d   = fal_q;
    cond_d  = cond_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          mode_d  = mode;
          thr_d   = threshold;
          tru_d   = tru_val;
          fal_d   = fal_val;
          addr_d  = base;
          rem_d   = count;
          state_d = (count == '0) ? ST_FIN : ST_COND;
        end
      end
      ST_COND: begin
        cond_d  = cmp_res;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // rem_q counts words still to finish, including the current one.
        if (mem_done) begin
          rem_d = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = ST_FIN;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_COND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done           = (state_q == ST_FIN);
    mem_write_en   = (state_q == ST_WRITE) && !mem_done;
    mem_write_data = '0;
    if (state_q == ST_WRITE) mem_write_data = cond_q ? tru_q : fal_q;
    mem_addr0      = (state_q == ST_IDLE) ? '0 : addr_q;
    dbg_state      = state_q;
  end

`ifdef IF_MEM_MAP_HIT_COUNT_EN
  logic [ADDR_WIDTH:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (state_q == ST_IDLE && go)          hit_d = '0;
    else if (state_q == ST_COND && cmp_res) hit_d = hit_q + (ADDR_WIDTH+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign hit_count = hit_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_if_mem_map.sv
// Scoreboard bench for if_mem_map: driver pushes expected writes and done
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_if_mem_map;
  localparam int W  = 32;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (unsigned) ----------------
  logic          go, done, mem_write_en, mem_done;
  logic [2:0]    mode;
  logic [W-1:0]  threshold, tru_val, fal_val, mem_write_data, mem_read_data;
  logic [AW-1:0] base, mem_addr0;
  logic [AW:0]   count, hit_count;
  logic [1:0]    dbg_state;

  if_mem_map #(.WIDTH(W), .ADDR_WIDTH(AW), .SIGNED(1'b0)) dut (
    .clk(clk), .reset(rst_n), .go(go), .done(done), .mode(mode),
    .threshold(threshold), .tru_val(tru_val), .fal_val(fal_val),
    .base(base), .count(count), .hit_count(hit_count),
    .mem_addr0(mem_addr0), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_data(mem_read_data),
    .mem_done(mem_done), .dbg_state(dbg_state)
  );

  // ---------------- signed DUT ----------------
  logic          s_go, s_done, s_we, s_ack;
  logic [W-1:0]  s_wdata, smem, s_img;
  logic [AW-1:0] s_addr;
  logic [AW:0]   s_hits;
  logic [1:0]    s_dbg;

  if_mem_map #(.WIDTH(W), .ADDR_WIDTH(AW), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(rst_n), .go(s_go), .done(s_done), .mode(3'd1),
    .threshold(32'd1), .tru_val(32'hAAAA), .fal_val(32'hBBBB),
    .base(4'd0), .count(5'd1), .hit_count(s_hits),
    .mem_addr0(s_addr), .mem_write_data(s_wdata),
    .mem_write_en(s_we), .mem_read_data(smem),
    .mem_done(s_ack), .dbg_state(s_dbg)
  );

  // ---------------- memory models ----------------
  logic [W-1:0] mem [16];
  logic [W-1:0] img [16];
  logic         load_req = 1'b0;
  logic         busy;
  int           dcnt;
  int           delay = 1;

  assign mem_read_data = mem[mem_addr0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      mem_done <= 1'b0;
      dcnt     <= 0;
    end else begin
      mem_done <= 1'b0;
      if (load_req) begin
        mem <= img;
      end else if (busy) begin
        if (dcnt == 1) begin
          mem_done <= 1'b1;
          busy     <= 1'b0;
        end
        dcnt <= dcnt - 1;
      end else if (mem_write_en) begin
        mem[mem_addr0] <= mem_write_data;
        if (delay == 1) mem_done <= 1'b1;
        else begin
          busy <= 1'b1;
          dcnt <= delay - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_ack <= 1'b0;
    else begin
      s_ack <= s_we;
      if (load_req) smem <= s_img;
      else if (s_we) smem <= s_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  logic [AW+W-1:0] exp_q[$];
  int              exp_lat_q[$];
  logic [AW:0]     exp_hit_q[$];
  int              vectors = 0;
  int              errors  = 0;
  int              start_cyc = 0;
  logic            done_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s: event with nothing expected", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write_en && !busy && !load_req) begin
        if (exp_q.size() == 0) fail_now("wr_unexpected");
        else chk("wr_addr_data", {mem_addr0, mem_write_data}, exp_q.pop_front());
      end
      if (busy) chk("we_hold", mem_write_en, 1'b1);
      if (done) begin
        chk("done_pulse", done_prev, 1'b0);
        if (exp_lat_q.size() == 0) fail_now("done_unexpected");
        else begin
          chk("latency", cyc - start_cyc, exp_lat_q.pop_front());
          chk("hit_count", hit_count, exp_hit_q.pop_front());
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // ---------------- driver ----------------
  function automatic logic model_cmp(input logic [2:0] m, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    case (m)
      3'd0:    return a < b;
      3'd1:    return a > b;
      3'd2:    return a == b;
      3'd3:    return a != b;
      3'd4:    return a <= b;
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_mem();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic start_job(input logic [2:0] m, input logic [W-1:0] thr,
                           input logic [W-1:0] tv, input logic [W-1:0] fv,
                           input logic [AW-1:0] b, input logic [AW:0] n, input int dly);
    logic [AW-1:0] a;
    logic          r;
    int            hits;
    a     = b;
    hits  = 0;
    delay = dly;
    for (int i = 0; i < int'(n); i++) begin
      r = model_cmp(m, img[a], thr);
      exp_q.push_back({a, r ? tv : fv});
      if (r) hits++;
      a = a + AW'(1);
    end
    exp_lat_q.push_back((dly + 2) * int'(n) + 1);
`ifdef IF_MEM_MAP_HIT_COUNT_EN
    exp_hit_q.push_back((AW+1)'(hits));
`else
    exp_hit_q.push_back('0);
`endif
    @(negedge clk);
    mode = m; threshold = thr; tru_val = tv; fal_val = fv; base = b; count = n;
    go = 1'b1;
    start_cyc = cyc;
    // Scramble operands once latched; the run must ignore them.
    @(negedge clk);
    mode = ~m; threshold = ~thr; tru_val = 32'hDEAD; fal_val = 32'hBEEF;
    base = ~b; count = 5'd7;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    go = 1'b0;
    if (!got) begin
      chk("done_timeout", 1'b0, 1'b1);
      exp_q.delete(); exp_lat_q.delete(); exp_hit_q.delete();
    end
    @(negedge clk);
    chk("wr_drain", exp_q.size(), 0);
  endtask

  task automatic run_job(input logic [2:0] m, input logic [W-1:0] thr,
                         input logic [W-1:0] tv, input logic [W-1:0] fv,
                         input logic [AW-1:0] b, input logic [AW:0] n, input int dly);
    start_job(m, thr, tv, fv, b, n, dly);
    wait_done();
  endtask

  task automatic set_img(input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input logic [W-1:0] a3, input int at);
    for (int i = 0; i < 16; i++) img[i] = '0;
    img[at] = a0; img[at+1] = a1; img[at+2] = a2; img[at+3] = a3;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    go = 1'b0; s_go = 1'b0; mode = '0; threshold = '0; tru_val = '0; fal_val = '0;
    base = '0; count = '0; s_img = '0;
    for (int i = 0; i < 16; i++) img[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 1'b0);
    chk("rst_we", mem_write_en, 1'b0);
    chk("rst_wdata", mem_write_data, '0);
    chk("rst_addr", mem_addr0, '0);
    chk("rst_hits", hit_count, '0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    // Unsigned LT: {1,7,9,3} < 5 -> {4,10,10,4}, done at cycle 13.
    set_img(1, 7, 9, 3, 0);
    load_mem();
    run_job(3'd0, 5, 4, 10, 4'd0, 5'd4, 1);
    chk("lt_m0", mem[0], 4); chk("lt_m1", mem[1], 10);
    chk("lt_m2", mem[2], 10); chk("lt_m3", mem[3], 4);

    // count=0: done at cycle 1, no writes.
    run_job(3'd0, 5, 4, 10, 4'd3, 5'd0, 1);

    // EQ with address wrap 14,15,0,1.
    set_img(0, 0, 0, 0, 0);
    load_mem();
    run_job(3'd2, 0, 32'h55, 32'h66, 4'd14, 5'd4, 1);
    chk("wrap_m14", mem[14], 32'h55); chk("wrap_m15", mem[15], 32'h55);
    chk("wrap_m0", mem[0], 32'h55);   chk("wrap_m1", mem[1], 32'h55);
    chk("wrap_m2", mem[2], 0);

    // Every operator, including the two undefined encodings.
    for (int m = 0; m < 8; m++) begin
      set_img(3, 5, 7, 5, 4);
      load_mem();
      run_job(3'(m), 5, 100 + m, 200 + m, 4'd4, 5'd4, 1);
    end
    chk("mode7_m4", mem[4], 207); chk("mode7_m6", mem[6], 207);

    // Full range: count = 16, starting mid-memory.
    for (int i = 0; i < 16; i++) img[i] = 3 * i;
    load_mem();
    run_job(3'd3, 0, 1, 2, 4'd3, 5'd16, 1);
    chk("full_m0", mem[0], 2); chk("full_m15", mem[15], 1);

    // Unsigned GT: FFFF_FFFF > 1 is true.
    set_img(32'hFFFF_FFFF, 0, 0, 0, 0);
    load_mem();
    run_job(3'd1, 1, 32'hAAAA, 32'hBBBB, 4'd0, 5'd1, 1);
    chk("ugt_m0", mem[0], 32'hAAAA);

    // Signed GT: -1 > 1 is false.
    s_img = 32'hFFFF_FFFF;
    load_mem();
    @(negedge clk) s_go = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (s_done) break;
      @(negedge clk);
    end
    chk("sgt_done", s_done, 1'b1);
    s_go = 1'b0;
    @(negedge clk);
    chk("sgt_mem", smem, 32'hBBBB);

    // Stalled memory: ack three cycles after the write.
    set_img(10, 20, 30, 0, 8);
    load_mem();
    run_job(3'd5, 20, 32'h11, 32'h22, 4'd8, 5'd3, 3);
    chk("stall_m8", mem[8], 32'h22); chk("stall_m9", mem[9], 32'h11);
    chk("stall_m10", mem[10], 32'h11);

    // Reset during WRITE of word 2 of 4, then a clean rerun.
    set_img(1, 7, 9, 3, 0);
    load_mem();
    start_job(3'd0, 5, 4, 10, 4'd0, 5'd4, 1);
    for (int k = 0; k < 100; k++) begin
      if (mem_write_en && mem_addr0 == 4'd1) break;
      @(negedge clk);
    end
    chk("rst_at_word2", mem_addr0, 4'd1);
    #2 rst_n = 1'b0;
    go = 1'b0;
    #1;
    chk("mid_rst_we", mem_write_en, 1'b0);
    chk("mid_rst_wdata", mem_write_data, '0);
    chk("mid_rst_addr", mem_addr0, '0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_hits", hit_count, '0);
    exp_q.delete(); exp_lat_q.delete(); exp_hit_q.delete();
    chk("mid_rst_m0", mem[0], 4); chk("mid_rst_m1", mem[1], 7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_mem();
    run_job(3'd0, 5, 4, 10, 4'd0, 5'd4, 1);
    chk("rerun_m0", mem[0], 4); chk("rerun_m1", mem[1], 10);
    chk("rerun_m2", mem[2], 10); chk("rerun_m3", mem[3], 4);

    repeat (3) @(negedge clk);
    chk("final_done_q", exp_lat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
